// File: rtl/hazard_scoreboard.sv
// Register-hazard scoreboard: tracks in-flight GPR writes, stalls on Tuse<Tnew, forwards ready data.
// Optional stall counter port stall_cnt when SCB_STATS_EN is defined.
module hazard_scoreboard #(
  parameter int unsigned DEPTH  = 3,
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned T_W    = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       freeze,
  input  logic                       iss_valid,
  input  logic [ADDR_W-1:0]          iss_addr,
  input  logic [T_W-1:0]             iss_tnew,
  input  logic [DATA_W-1:0]          iss_data,
  input  logic [DEPTH-1:0]           res_valid,
  input  logic [DEPTH*DATA_W-1:0]    res_data,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  input  logic [NUM_RD*T_W-1:0]      rd_tuse,
  input  logic [NUM_RD*DATA_W-1:0]   rd_rf_data,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_fwd,
  output logic                       stall
`ifdef SCB_STATS_EN
  ,
  output logic [31:0]                stall_cnt
`endif
);

  logic [ADDR_W-1:0] entAddr [DEPTH];
  logic [T_W-1:0]    entTnew [DEPTH];
  logic [DATA_W-1:0] entData [DEPTH];

  logic [NUM_RD-1:0] portStall;
  logic              hit;
  logic [T_W-1:0]    hitTnew;
  logic [DATA_W-1:0] hitData;

  // The oldest stage's result lands in the register file, never in an entry.
  logic unusedOldestRes;
  assign unusedOldestRes = ^{res_valid[DEPTH-1], res_data[(DEPTH-1)*DATA_W +: DATA_W]};

  function automatic logic [T_W-1:0] decT(input logic [T_W-1:0] t);
    return (t == '0) ? '0 : t - T_W'(1);
  endfunction

  // Per-port lookup: scan oldest to youngest so the youngest match wins.
  always_comb begin
    portStall = '0;
    rd_fwd    = '0;
    rd_data   = rd_rf_data;
    hit       = 1'b0;
    hitTnew   = '0;
    hitData   = '0;
    for (int p = 0; p < int'(NUM_RD); p++) begin
      hit     = 1'b0;
      hitTnew = '0;
      hitData = '0;
      for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
        if (entAddr[k] == rd_addr[p*ADDR_W +: ADDR_W]) begin
          hit     = 1'b1;
          hitTnew = entTnew[k];
          hitData = entData[k];
        end
      end
      if (rd_addr[p*ADDR_W +: ADDR_W] == '0) hit = 1'b0;
      portStall[p] = hit && (rd_tuse[p*T_W +: T_W] < hitTnew);
      if (hit && (hitTnew == '0)) begin
        rd_fwd[p]                    = 1'b1;
        rd_data[p*DATA_W +: DATA_W]  = hitData;
      end
    end
  end

  assign stall = |portStall;

  // Pending-write shift chain; a stalled or zero-destination issue enters as a bubble.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < int'(DEPTH); k++) begin
        entAddr[k] <= '0;
        entTnew[k] <= '0;
        entData[k] <= '0;
      end
    end else if (!freeze) begin
      if (iss_valid && !stall && (iss_addr != '0)) begin
        entAddr[0] <= iss_addr;
        entTnew[0] <= decT(iss_tnew);
        entData[0] <= iss_data;
      end else begin
        entAddr[0] <= '0;
        entTnew[0] <= '0;
        entData[0] <= '0;
      end
      for (int k = 1; k < int'(DEPTH); k++) begin
        entAddr[k] <= entAddr[k-1];
        entTnew[k] <= decT(entTnew[k-1]);
        entData[k] <= res_valid[k-1] ? res_data[(k-1)*DATA_W +: DATA_W] : entData[k-1];
      end
    end
  end

`ifdef SCB_STATS_EN
  // Saturating count of cycles the pipeline was actually held by a hazard.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= 32'd0;
    end else if (stall && !freeze && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: stimulus queues expected outputs, a negedge monitor compares.
module tb_hazard_scoreboard;

  localparam logic [31:0] RF0 = 32'hAAAA_0000;
  localparam logic [31:0] RF1 = 32'hBBBB_1111;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        freeze;
  logic        iss_valid;
  logic [4:0]  iss_addr;
  logic [1:0]  iss_tnew;
  logic [31:0] iss_data;
  logic [2:0]  res_valid;
  logic [95:0] res_data;
  logic [9:0]  rd_addr;
  logic [3:0]  rd_tuse;
  logic [63:0] rd_rf_data;
  logic [63:0] rd_data;
  logic [1:0]  rd_fwd;
  logic        stall;
`ifdef SCB_STATS_EN
  logic [31:0] stall_cnt;
`endif

  hazard_scoreboard dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .freeze     (freeze),
    .iss_valid  (iss_valid),
    .iss_addr   (iss_addr),
    .iss_tnew   (iss_tnew),
    .iss_data   (iss_data),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .rd_addr    (rd_addr),
    .rd_tuse    (rd_tuse),
    .rd_rf_data (rd_rf_data),
    .rd_data    (rd_data),
    .rd_fwd     (rd_fwd),
    .stall      (stall)
`ifdef SCB_STATS_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic        s;
    logic [1:0]  f;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [31:0] cnt;
  } expT;

  expT         expQ[$];
  expT         monE;
  int          errors = 0;
  int          checks = 0;
  int unsigned expCnt = 0;
  logic        lastStall = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic pushExp(input string nm, input logic s, input logic [1:0] f,
                         input logic [31:0] d0, input logic [31:0] d1);
    expT e;
    e.nm = nm; e.s = s; e.f = f; e.d0 = d0; e.d1 = d1; e.cnt = expCnt;
    expQ.push_back(e);
    lastStall = s;
  endtask

  task automatic step();
    if (lastStall && !freeze) expCnt++;
    lastStall = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic iss(input logic v, input logic [4:0] a, input logic [1:0] t, input logic [31:0] d);
    iss_valid = v; iss_addr = a; iss_tnew = t; iss_data = d;
  endtask

  task automatic setRd(input int p, input logic [4:0] a, input logic [1:0] tu);
    rd_addr[p*5 +: 5] = a;
    rd_tuse[p*2 +: 2] = tu;
  endtask

  // Monitor: one expectation per cycle, sampled on the falling edge.
  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      monE = expQ.pop_front();
      chk({monE.nm, ".stall"}, 32'(stall), 32'(monE.s));
      chk({monE.nm, ".fwd"}, 32'(rd_fwd), 32'(monE.f));
      chk({monE.nm, ".data0"}, rd_data[31:0], monE.d0);
      chk({monE.nm, ".data1"}, rd_data[63:32], monE.d1);
`ifdef SCB_STATS_EN
      chk({monE.nm, ".cnt"}, stall_cnt, monE.cnt);
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; freeze = 1'b0;
    iss(1'b0, 5'd0, 2'd0, 32'd0);
    res_valid = '0; res_data = '0;
    rd_addr = '0; rd_tuse = '0;
    rd_rf_data = {RF1, RF0};
    @(posedge clk); #1;
    pushExp("reset", 1'b0, 2'b00, RF0, RF1); step();
    reset_n = 1'b1;

    // Load-use: tnew 3 against tuse 1 stalls exactly one cycle, then forwards from stage 1.
    iss(1'b1, 5'd8, 2'd3, 32'd0);
    pushExp("lu_issue", 1'b0, 2'b00, RF0, RF1); step();
    iss(1'b0, 5'd0, 2'd0, 32'd0); setRd(0, 5'd8, 2'd1);
    pushExp("lu_stall", 1'b1, 2'b00, RF0, RF1); step();
    res_valid = 3'b010; res_data[63:32] = 32'hDEAD_BEEF;
    pushExp("lu_resolve", 1'b0, 2'b00, RF0, RF1); step();
    res_valid = 3'b000;
    pushExp("lu_fwd", 1'b0, 2'b01, 32'hDEAD_BEEF, RF1); step();
    pushExp("lu_retired", 1'b0, 2'b00, RF0, RF1); step();

    // Link value known at issue; both ports reading it agree.
    iss(1'b1, 5'd31, 2'd0, 32'h0000_3008); setRd(0, 5'd0, 2'd0);
    pushExp("link_issue", 1'b0, 2'b00, RF0, RF1); step();
    iss(1'b0, 5'd0, 2'd0, 32'd0); setRd(0, 5'd31, 2'd0); setRd(1, 5'd31, 2'd0);
    pushExp("link_fwd", 1'b0, 2'b11, 32'h0000_3008, 32'h0000_3008); step();

    // Zero register never matches.
    setRd(1, 5'd0, 2'd0); setRd(0, 5'd0, 2'd0); iss(1'b1, 5'd0, 2'd3, 32'd0);
    pushExp("zero_issue", 1'b0, 2'b00, RF0, RF1); step();
    iss(1'b0, 5'd0, 2'd0, 32'd0);
    pushExp("zero_read", 1'b0, 2'b00, RF0, RF1); step();

    // Youngest matching entry wins over older ones.
    iss(1'b1, 5'd5, 2'd0, 32'h11);
    pushExp("pri_first", 1'b0, 2'b00, RF0, RF1); step();
    iss(1'b1, 5'd5, 2'd0, 32'h22); setRd(0, 5'd5, 2'd0);
    pushExp("pri_one", 1'b0, 2'b01, 32'h11, RF1); step();
    iss(1'b0, 5'd0, 2'd0, 32'd0);
    pushExp("pri_young", 1'b0, 2'b01, 32'h22, RF1); step();
    iss(1'b1, 5'd6, 2'd3, 32'd0); setRd(0, 5'd0, 2'd0);
    pushExp("pri2_old", 1'b0, 2'b00, RF0, RF1); step();
    iss(1'b1, 5'd6, 2'd0, 32'h66);
    pushExp("pri2_young", 1'b0, 2'b00, RF0, RF1); step();
    iss(1'b0, 5'd0, 2'd0, 32'd0); setRd(0, 5'd6, 2'd0);
    pushExp("pri_old_ignored", 1'b0, 2'b01, 32'h66, RF1); step();

    // Freeze holds entries, ignores issue and results; release resumes shifting.
    iss(1'b1, 5'd9, 2'd2, 32'd0); setRd(0, 5'd0, 2'd0);
    pushExp("frz_load", 1'b0, 2'b00, RF0, RF1); step();
    for (int i = 0; i < 4; i++) begin
      freeze = 1'b1; iss(1'b1, 5'd12, 2'd0, 32'h12);
      res_valid = 3'b001; res_data[31:0] = 32'h77;
      setRd(0, 5'd9, 2'd0); setRd(1, 5'd12, 2'd0);
      pushExp("frz_hold", 1'b1, 2'b00, RF0, RF1); step();
    end
    freeze = 1'b0; iss(1'b0, 5'd0, 2'd0, 32'd0);
    res_valid = 3'b001; res_data[31:0] = 32'h99;
    pushExp("frz_release", 1'b1, 2'b00, RF0, RF1); step();
    res_valid = 3'b000;
    pushExp("frz_resume", 1'b0, 2'b01, 32'h99, RF1); step();

    // Asynchronous reset between edges clears a live stall.
    setRd(1, 5'd0, 2'd0); setRd(0, 5'd0, 2'd0); iss(1'b1, 5'd10, 2'd3, 32'd0);
    pushExp("rst_load", 1'b0, 2'b00, RF0, RF1); step();
    iss(1'b0, 5'd0, 2'd0, 32'd0); setRd(0, 5'd10, 2'd0);
    pushExp("rst_prestall", 1'b1, 2'b00, RF0, RF1); step();
    reset_n = 1'b0; expCnt = 0;
    pushExp("rst_async", 1'b0, 2'b00, RF0, RF1); step();
    reset_n = 1'b1;
    pushExp("rst_after", 1'b0, 2'b00, RF0, RF1); step();

    for (int i = 0; i < 10 && expQ.size() > 0; i++) @(posedge clk);
    chk("drain", 32'(expQ.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
